// File: rtl/emac_tx_client_fifo.sv
// Store-and-forward transmit FIFO between user logic and an EMAC client TX port.
// Frames are written byte by byte with an end-of-frame marker, and only complete
// frames are handed to the EMAC. Each byte is kept with its eof flag.
// The EMAC handshake is: hold the first byte until TXACK, then stream one byte per
// cycle. A collision either rewinds to the start of the frame or drops the frame.
// The frame-end queue holds two entries, so at most two complete frames are stored
// at once. FULL is also asserted while both entries are in use.
module emac_tx_client_fifo #(
  parameter int ADDRW = 11
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [7:0]       WRDATA,
  input  logic             WREN,
  input  logic             WREOF,
  input  logic             WRERR,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic [ADDRW-1:0] FRAMECNT,
  output logic [7:0]       TXD,
  output logic             TXDVLD,
  output logic             TXFIRSTBYTE,
  output logic             TXUNDERRUN,
  input  logic             TXACK,
  input  logic             TXCOLLISION,
  input  logic             TXRETRANSMIT
);

  localparam int               DEPTH    = 1 << ADDRW;
  localparam logic [ADDRW-1:0] PTR_ONE  = {{(ADDRW-1){1'b0}}, 1'b1};
  localparam logic [ADDRW-1:0] PTR_ZERO = {ADDRW{1'b0}};
  localparam logic [ADDRW-1:0] CNT_TWO  = {{(ADDRW-2){1'b0}}, 2'b10};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_SEND     = 2'd2
  } tx_state_t;

  // Pointer increment, wrapping modulo the array depth.
  function automatic logic [ADDRW-1:0] ptr_inc(input logic [ADDRW-1:0] p);
    return p + PTR_ONE;
  endfunction

  logic [8:0]       mem_r [DEPTH];
  logic [ADDRW-1:0] wr_ptr_r;
  logic [ADDRW-1:0] wr_start_r;
  logic [ADDRW-1:0] rd_ptr_r;
  logic [ADDRW-1:0] rd_start_r;
  logic [ADDRW-1:0] framecnt_r;
  logic [ADDRW-1:0] fe_q_r [2];
  logic             drop_r;
  logic             overflow_r;
  tx_state_t        state_r;
  logic [7:0]       txd_r;
  logic             txdvld_r;

  logic             full_s;
  logic             wr_en_s;
  logic             commit_s;
  logic             ovf_s;
  logic             drop_nxt_s;
  logic [ADDRW-1:0] wr_ptr_nxt_s;
  logic [ADDRW-1:0] wr_start_nxt_s;

  tx_state_t        state_nxt_s;
  logic [ADDRW-1:0] rd_ptr_nxt_s;
  logic [ADDRW-1:0] rd_start_nxt_s;
  logic             done_s;
  logic             cur_eof_s;

  // Full when the next write would reach the oldest unreleased byte, or both frame-end slots are taken.
  always_comb begin
    full_s = (ptr_inc(wr_ptr_r) == rd_start_r) || (framecnt_r >= CNT_TWO);
  end

  // Write-side decisions: abort, drop after overflow, overflow detection, store and commit.
  always_comb begin
    wr_en_s        = 1'b0;
    commit_s       = 1'b0;
    ovf_s          = 1'b0;
    drop_nxt_s     = drop_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    wr_start_nxt_s = wr_start_r;
    if (WRERR) begin
      wr_ptr_nxt_s = wr_start_r;
      drop_nxt_s   = 1'b0;
    end else if (WREN) begin
      if (drop_r) begin
        drop_nxt_s = ~WREOF;
      end else if (full_s) begin
        wr_ptr_nxt_s = wr_start_r;
        ovf_s        = 1'b1;
        drop_nxt_s   = ~WREOF;
      end else begin
        wr_en_s      = 1'b1;
        wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        if (WREOF) begin
          commit_s       = 1'b1;
          wr_start_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
          wr_start_nxt_s = wr_start_r;
        end
      end
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // Transmit decisions: start, wait for ack, stream, complete, rewind or discard.
  always_comb begin
    state_nxt_s    = state_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    rd_start_nxt_s = rd_start_r;
    done_s         = 1'b0;
    cur_eof_s      = mem_r[rd_ptr_r][8];
    case (state_r)
      ST_IDLE: begin
        if (framecnt_r != PTR_ZERO) begin
          state_nxt_s = ST_WAIT_ACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK, ST_SEND: begin
        if (TXCOLLISION && TXRETRANSMIT) begin
          rd_ptr_nxt_s = rd_start_r;
          state_nxt_s  = ST_WAIT_ACK;
        end else if (TXCOLLISION) begin
          rd_ptr_nxt_s   = ptr_inc(fe_q_r[0]);
          rd_start_nxt_s = ptr_inc(fe_q_r[0]);
          done_s         = 1'b1;
          state_nxt_s    = ST_IDLE;
        end else if ((state_r == ST_SEND) || TXACK) begin
          rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
          if (cur_eof_s) begin
            rd_start_nxt_s = ptr_inc(rd_ptr_r);
            done_s         = 1'b1;
            state_nxt_s    = ST_IDLE;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Byte storage; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {WREOF, WRDATA};
    end
  end

  // Write pointers, drop flag and overflow pulse.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_r   <= PTR_ZERO;
      wr_start_r <= PTR_ZERO;
      drop_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      wr_start_r <= wr_start_nxt_s;
      drop_r     <= drop_nxt_s;
      overflow_r <= ovf_s;
    end
  end

  // Transmit FSM with registered TXD/TXDVLD looking ahead to the next read address.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r    <= ST_IDLE;
      rd_ptr_r   <= PTR_ZERO;
      rd_start_r <= PTR_ZERO;
      txdvld_r   <= 1'b0;
      txd_r      <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      rd_start_r <= rd_start_nxt_s;
      txdvld_r   <= (state_nxt_s != ST_IDLE);
      if (state_nxt_s != ST_IDLE) begin
        txd_r <= mem_r[rd_ptr_nxt_s][7:0];
      end else begin
        txd_r <= 8'h00;
      end
    end
  end

  // Complete-frame count and the frame-end queue (head = frame currently at rd_start).
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      framecnt_r <= PTR_ZERO;
      fe_q_r[0]  <= PTR_ZERO;
      fe_q_r[1]  <= PTR_ZERO;
    end else begin
      case ({commit_s, done_s})
        2'b10: begin
          framecnt_r <= framecnt_r + PTR_ONE;
          if (framecnt_r == PTR_ZERO) begin
            fe_q_r[0] <= wr_ptr_r;
          end else begin
            fe_q_r[1] <= wr_ptr_r;
          end
        end
        2'b01: begin
          framecnt_r <= framecnt_r - PTR_ONE;
          fe_q_r[0]  <= fe_q_r[1];
        end
        2'b11: begin
          if (framecnt_r == PTR_ONE) begin
            fe_q_r[0] <= wr_ptr_r;
          end else begin
            fe_q_r[0] <= fe_q_r[1];
            fe_q_r[1] <= wr_ptr_r;
          end
        end
        default: begin
          framecnt_r <= framecnt_r;
        end
      endcase
    end
  end

  assign FULL        = full_s;
  assign OVERFLOW    = overflow_r;
  assign FRAMECNT    = framecnt_r;
  assign TXD         = txd_r;
  assign TXDVLD      = txdvld_r;
  assign TXFIRSTBYTE = 1'b0;
  assign TXUNDERRUN  = 1'b0;

endmodule

// File: doc/emac_tx_client_fifo.md
EMAC_TX_CLIENT_FIFO -- requirements
Module: emac_tx_client_fifo

Interface
REQ-001 SHALL have parameter ADDRW, default 11, meaning log2 of the FIFO depth in bytes (depth 2048).
REQ-002 SHALL have ports CLK, input, 1 bit, the TX client clock shared with the EMAC client TX clock input.
REQ-003 SHALL have ports RESETN, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have ports WRDATA, input, 8 bits, frame byte from the user logic.
REQ-005 SHALL have ports WREN, input, 1 bit, WRDATA valid this cycle.
REQ-006 SHALL have ports WREOF, input, 1 bit, qualifies WREN: this byte is the last byte of the frame.
REQ-007 SHALL have ports WRERR, input, 1 bit, abort the frame currently being written.
REQ-008 SHALL have ports FULL, output, 1 bit, FIFO cannot accept a byte this cycle.
REQ-009 SHALL have ports OVERFLOW, output, 1 bit, one-cycle pulse when a frame is dropped for lack of space.
REQ-010 SHALL have ports FRAMECNT, output, ADDRW bits, number of complete frames stored.
REQ-011 SHALL have ports TXD, output, 8 bits, byte to the EMAC client TXD[7:0].
REQ-012 SHALL have ports TXDVLD, output, 1 bit, to the EMAC client TXDVLD.
REQ-013 SHALL have ports TXFIRSTBYTE and TXUNDERRUN, output, 1 bit each, to the EMAC; both held 0.
REQ-014 SHALL have ports TXACK, TXCOLLISION and TXRETRANSMIT, input, 1 bit each, from the EMAC client TX interface.

Function
REQ-015 SHALL store 9-bit entries {eof, byte} in a 2^ADDRW array with asynchronous read; pointers wrap modulo 2^ADDRW.
REQ-016 SHALL keep these pointers: wr_ptr (next write), wr_start (start of the frame being written), rd_ptr (next read), rd_start (start of the frame being transmitted).
REQ-017 SHALL assert FULL when wr_ptr+1 == rd_start; reclaimed space is released only when a frame completes.
REQ-018 On a write (WREN=1, FULL=0, not dropping), SHALL store the byte and increment wr_ptr.
REQ-019 If WREOF=1 on that write, SHALL also set wr_start to the new wr_ptr (frame commit).
REQ-020 If WREN=1 while FULL=1, SHALL set wr_ptr to wr_start and pulse OVERFLOW.
REQ-021 After an overflow, SHALL ignore writes up to and including the next WREOF byte.
REQ-022 If WRERR=1, SHALL set wr_ptr to wr_start and ignore WREN that cycle; a frame is never partially committed.
REQ-023 SHALL have transmit states IDLE, WAIT_ACK and SEND.
REQ-024 In IDLE, with FRAMECNT>0, SHALL go to WAIT_ACK next cycle.
REQ-025 In WAIT_ACK, SHALL drive TXDVLD=1 and TXD=mem[rd_ptr], holding both until TXACK=1.
REQ-026 On TXACK in WAIT_ACK, SHALL increment rd_ptr and go to SEND.
REQ-027 If the acked byte has eof=1, SHALL instead complete the frame and go to IDLE.
REQ-028 In SEND, SHALL drive TXDVLD=1 and TXD=mem[rd_ptr] every cycle and increment rd_ptr.
REQ-029 When the presented byte has eof=1, SHALL complete the frame and go to IDLE; TXDVLD is 0 the next cycle.
REQ-030 Frame completion SHALL set rd_start = rd_ptr+1 and decrement FRAMECNT.
REQ-031 A commit and a completion in the same cycle SHALL leave FRAMECNT unchanged.
REQ-032 TXCOLLISION=1 with TXRETRANSMIT=1, in WAIT_ACK or SEND, SHALL set rd_ptr to rd_start and go to WAIT_ACK (rewind and resend).
REQ-033 TXCOLLISION=1 with TXRETRANSMIT=0 SHALL discard the frame: set rd_ptr and rd_start to the byte after its eof entry, decrement FRAMECNT, and go to IDLE.
REQ-034 To support REQ-033, SHALL keep a per-frame end pointer, latched at commit into a 2-entry frame-end queue.
REQ-035 SHALL start transmission only for complete frames (store-and-forward), so underrun never occurs.

Reset
REQ-036 RESETN=0 SHALL asynchronously clear all pointers, FRAMECNT, OVERFLOW, TXDVLD, TXD and the drop flag, and set the state to IDLE.
REQ-037 Array contents are not reset.
REQ-038 Write logic and transmit logic SHALL resume on the first CLK edge after RESETN deasserts.
REQ-039 Reset mid-frame SHALL discard all stored data.

Verification
REQ-040 Write a 64-byte frame 0x00..0x3F with EOF on the last byte, TXACK 3 cycles after TXDVLD rises -> TXD holds 0x00 for 4 cycles, then 0x01..0x3F on consecutive cycles; TXDVLD falls; FRAMECNT 1->0.
REQ-041 Write 10 bytes then WRERR, then a 60-byte frame -> only the 60-byte frame is transmitted; FRAMECNT peaks at 1.
REQ-042 ADDRW=4: write a 20-byte frame -> FULL at 15 stored bytes, OVERFLOW pulses once, FRAMECNT stays 0, and a following 8-byte frame transmits intact.
REQ-043 TXCOLLISION+TXRETRANSMIT at byte 12 of a 64-byte frame -> TXDVLD holds with TXD=byte 0 until TXACK, then the full frame resends.
REQ-044 TXCOLLISION alone mid-frame with two frames queued -> the first frame is dropped, FRAMECNT 2->1, and the second frame starts in WAIT_ACK with its first byte.
REQ-045 RESETN low during SEND -> TXDVLD=0 and FRAMECNT=0 immediately; FULL=0.
